// File: rtl/fp_add_pipe_pkg.sv
// ============================================================================
// fp_add_pipe_pkg : shared widths, constants and stage records for fp_add_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_add_pipe_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int EXT_W  = MAN_W + 4;   // hidden bit + fraction + guard/round/sticky

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  // First exponent that no longer encodes a finite number
  localparam logic signed [9:0] EXP_SAT = 10'(2 * BIAS + 1);

  typedef struct packed {
    logic                 sign;
    logic                 eff_sub;
    logic [EXP_W-1:0]     exp;
    logic [EXT_W-1:0]     mant_l;
    logic [EXT_W-1:0]     mant_s;
    logic                 special;
    logic [WORD_W-1:0]    special_val;
    logic                 invalid;
  } s1_rec_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [EXT_W:0]       mant;
    logic                 special;
    logic [WORD_W-1:0]    special_val;
    logic                 invalid;
  } s2_rec_t;

endpackage

`default_nettype wire

// File: rtl/fp_add_pipe_if.sv
// ============================================================================
// fp_add_pipe_if : operand/result handshake bundle for fp_add_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

interface fp_add_pipe_if;
  import fp_add_pipe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum;
  logic [2:0]        flags;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, sum, flags
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, sum, flags
  );

endinterface

`default_nettype wire

// File: rtl/fp_lzc27.sv
// ============================================================================
// fp_lzc27 : leading-zero count of a 27-bit word (27 when the word is zero)
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write count
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_pipe.sv
// ============================================================================
// fp_add_pipe : 3-stage IEEE-754 single-precision adder with valid/ready flow
// Macros: FP_ADD_RNE_EN selects round-to-nearest-even (default truncates).
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_add_pipe
  import fp_add_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_add_pipe_if.slave bus
);

  logic    w_adv;
  logic    r_v1, r_v2, r_v3;
  s1_rec_t w_s1, r_s1;
  s2_rec_t w_s2, r_s2;
  logic [WORD_W-1:0] r_sum, w_sum_n;
  logic [2:0]        r_flags, w_flags_n;

  assign w_adv         = ~r_v3 | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v3;
  assign bus.sum       = r_sum;
  assign bus.flags     = r_flags;

  // ---------------- S1: unpack, classify, swap, align ----------------
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [EXP_W+MAN_W-1:0] w_mag_a, w_mag_b, w_mag_l, w_mag_s;
  logic             w_a_ge;
  logic [EXP_W-1:0] w_el, w_es, w_dist;
  logic [EXT_W-1:0] w_ml_ext, w_ms_ext, w_ms_sh;

  assign {w_sa, w_ea, w_fa} = bus.op_a;
  assign {w_sb, w_eb, w_fb} = bus.op_b;
  assign w_a_nan = (&w_ea) & (|w_fa);
  assign w_b_nan = (&w_eb) & (|w_fb);
  assign w_a_inf = (&w_ea) & ~(|w_fa);
  assign w_b_inf = (&w_eb) & ~(|w_fb);

  // Exponent zero covers both zeros and denormals: both become signed zero
  assign w_mag_a = (w_ea == '0) ? '0 : {w_ea, w_fa};
  assign w_mag_b = (w_eb == '0) ? '0 : {w_eb, w_fb};
  assign w_a_ge  = (w_mag_a >= w_mag_b);
  assign w_mag_l = w_a_ge ? w_mag_a : w_mag_b;
  assign w_mag_s = w_a_ge ? w_mag_b : w_mag_a;
  assign w_el    = w_mag_l[EXP_W+MAN_W-1:MAN_W];
  assign w_es    = w_mag_s[EXP_W+MAN_W-1:MAN_W];
  assign w_dist  = w_el - w_es;
  assign w_ml_ext = (w_el == '0) ? '0 : {1'b1, w_mag_l[MAN_W-1:0], 3'b000};
  assign w_ms_ext = (w_es == '0) ? '0 : {1'b1, w_mag_s[MAN_W-1:0], 3'b000};

  always_comb begin
    w_ms_sh = '0;
    if (w_dist >= 8'd26) begin
      w_ms_sh = {{(EXT_W-1){1'b0}}, |w_ms_ext};
    end else begin
      w_ms_sh    = w_ms_ext >> w_dist[4:0];
      w_ms_sh[0] = w_ms_sh[0] | (|(w_ms_ext & ~({EXT_W{1'b1}} << w_dist[4:0])));
    end
  end

  always_comb begin
    w_s1             = '0;
    w_s1.sign        = w_a_ge ? w_sa : w_sb;
    w_s1.eff_sub     = w_sa ^ w_sb;
    w_s1.exp         = w_el;
    w_s1.mant_l      = w_ml_ext;
    w_s1.mant_s      = w_ms_sh;
    w_s1.special     = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    w_s1.invalid     = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb));
    if (w_s1.invalid)  w_s1.special_val = QNAN;
    else if (w_a_inf)  w_s1.special_val = {w_sa, POS_INF[WORD_W-2:0]};
    else               w_s1.special_val = {w_sb, POS_INF[WORD_W-2:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_adv) begin
      r_v1 <= bus.in_valid;
      r_s1 <= w_s1;
    end
  end

  // ---------------- S2: signed mantissa add/subtract ----------------
  logic [EXT_W:0] w_msum;

  assign w_msum = r_s1.eff_sub ? ({1'b0, r_s1.mant_l} - {1'b0, r_s1.mant_s})
                               : ({1'b0, r_s1.mant_l} + {1'b0, r_s1.mant_s});

  always_comb begin
    w_s2             = '0;
    w_s2.sign        = (r_s1.eff_sub && (w_msum == '0)) ? 1'b0 : r_s1.sign;
    w_s2.exp         = r_s1.exp;
    w_s2.mant        = w_msum;
    w_s2.special     = r_s1.special;
    w_s2.special_val = r_s1.special_val;
    w_s2.invalid     = r_s1.invalid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      r_s2 <= w_s2;
    end
  end

  // ---------------- S3: normalize, round, pack ----------------
  logic [4:0]        w_lz;
  logic              w_carry;
  logic [EXT_W-1:0]  w_norm;
  logic signed [9:0] w_exp_n, w_exp_r;
  logic              w_up, w_inexact;
  logic [MAN_W:0]    w_frac;
  logic [WORD_W-1:0] w_ovf_val;

  fp_lzc27 u_lzc (
    .value (r_s2.mant[EXT_W-1:0]),
    .count (w_lz)
  );

  assign w_carry = r_s2.mant[EXT_W];
  assign w_norm  = w_carry ? {r_s2.mant[EXT_W:2], |r_s2.mant[1:0]}
                           : (r_s2.mant[EXT_W-1:0] << w_lz);
  assign w_exp_n = w_carry ? ({2'b00, r_s2.exp} + 10'd1)
                           : ({2'b00, r_s2.exp} - {5'b00000, w_lz});
  assign w_inexact = |w_norm[2:0];

`ifdef FP_ADD_RNE_EN
  assign w_up      = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_ovf_val = {r_s2.sign, POS_INF[WORD_W-2:0]};
`else
  assign w_up      = 1'b0;
  assign w_ovf_val = {r_s2.sign, POS_INF[WORD_W-2:0] - 31'd1};
`endif

  // A carry out of the fraction leaves it zero and bumps the exponent
  assign w_frac  = {1'b0, w_norm[EXT_W-2:3]} + {{MAN_W{1'b0}}, w_up};
  assign w_exp_r = w_exp_n + {9'b0, w_frac[MAN_W]};

  always_comb begin
    w_sum_n   = '0;
    w_flags_n = '0;
    if (r_s2.special) begin
      w_sum_n   = r_s2.special_val;
      w_flags_n = {r_s2.invalid, 2'b00};
    end else if (!w_norm[EXT_W-1]) begin
      w_sum_n   = {r_s2.sign, {(WORD_W-1){1'b0}}};
    end else if (w_exp_n <= 10'sd0) begin
      w_sum_n   = {r_s2.sign, {(WORD_W-1){1'b0}}};
      w_flags_n = 3'b001;
    end else if (w_exp_r >= EXP_SAT) begin
      w_sum_n   = w_ovf_val;
      w_flags_n = 3'b011;
    end else begin
      w_sum_n   = {r_s2.sign, w_exp_r[EXP_W-1:0], w_frac[MAN_W-1:0]};
      w_flags_n = {2'b00, w_inexact};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v3    <= 1'b0;
      r_sum   <= '0;
      r_flags <= '0;
    end else if (w_adv) begin
      r_v3    <= r_v2;
      r_sum   <= w_sum_n;
      r_flags <= w_flags_n;
    end
  end

endmodule

`default_nettype wire

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 Parameters: none; width fixed at 32 bits (IEEE-754 single), latency fixed at 3 cycles.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  op_a/op_b carry a new operand pair this cycle.
REQ-005 in_ready  output  1  block accepts the pair when in_valid & in_ready.
REQ-006 op_a  input  32  first addend (accumulated operand from the upstream holding stage).
REQ-007 op_b  input  32  second addend.
REQ-008 out_valid  output  1  sum holds a result.
REQ-009 out_ready  input  1  consumer takes the result when out_valid & out_ready.
REQ-010 sum  output  32  IEEE-754 single result of op_a + op_b.
REQ-011 flags  output  3  {invalid, overflow, inexact}, aligned with sum.

Function
REQ-012 The pipeline SHALL have three stages:
- S1: unpack, classify, swap so the larger magnitude is first, right-shift the smaller mantissa with guard/round/sticky.
- S2: signed add/subtract of 27-bit extended mantissas.
- S3: leading-zero normalize, round, pack.
REQ-013 Latency SHALL be exactly 3 cycles from the accept edge to out_valid when no stall occurs; throughput SHALL be one pair per cycle.
REQ-014 in_ready SHALL equal ~out_valid | out_ready; when in_ready=0, all stages SHALL hold their contents and valid bits.
REQ-015 Valid bubbles SHALL propagate; an empty stage SHALL never raise out_valid.
REQ-016 sum and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 Denormal inputs SHALL be flushed to signed zero; denormal results SHALL flush to signed zero and set inexact.
REQ-018 Special cases:
- NaN operand, or +inf + -inf: result 0x7FC00000 with invalid=1.
- inf + finite: that inf.
- Exact cancellation: +0.
- (-0)+(-0): -0.
REQ-019 An exponent overflow after rounding SHALL produce signed inf with overflow=1 and inexact=1.
REQ-020 A shift distance of 26 or more SHALL collapse the smaller operand into the sticky bit only.
REQ-021 inexact SHALL be set whenever guard|round|sticky is nonzero after normalization.

Reset
REQ-022 While rst=0, all stage valid bits, sum, and flags SHALL be 0; in_ready SHALL be 1 one cycle after rst deasserts.
REQ-023 Reset asserted mid-operation SHALL discard every in-flight pair; no result from before reset SHALL appear afterwards.

Configuration
REQ-024 With FP_ADD_RNE_EN defined, S3 SHALL round to nearest, ties to even.
REQ-025 Without FP_ADD_RNE_EN, S3 SHALL truncate toward zero; inexact is still reported, and overflow SHALL saturate to 0x7F7FFFFF/0xFF7FFFFF instead of inf.

Structure
REQ-026 A shared package SHALL hold:
- Field widths (EXP_W=8, MAN_W=23) and BIAS=127.
- Constants QNAN=0x7FC00000 and POS_INF=0x7F800000.
- The S1→S2 and S2→S3 stage-record typedefs.
REQ-027 The 27-bit leading-zero counter SHALL be a separate sub-module, fp_lzc27, instantiated in S3.

Verification
REQ-028 0x3F800000 + 0x3F800000, out_ready=1 → sum=0x40000000, flags=000, out_valid exactly 3 cycles after accept.
REQ-029 0x3FC00000 + 0xBFC00000 → 0x00000000; 0x7F800000 + 0xFF800000 → 0x7FC00000 with invalid=1.
REQ-030 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow=1 under FP_ADD_RNE_EN; 0x7F7FFFFF without it.
REQ-031 0x3F800000 + 0x33C00000 → 0x3F800001 under RNE, 0x3F800000 truncated; 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even); inexact=1 in all three cases.
REQ-032 Five back-to-back pairs with out_ready held low cycles 4-7 → in_ready=0 during the stall, no result lost or duplicated, results in order.
REQ-033 Assert rst with three pairs in flight → out_valid=0 immediately; after release, only post-reset pairs emerge.
